pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control.sv | 155 +++++++++++++++
 tb/tb_pipe_control.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// Pipeline control for a 5-stage in-order core: opcode decode, ID/EX, EX/MEM and MEM/WB
// control registers, load-use stall, branch flush, sticky illegal-op flag and event counters.
module pipe_control #(
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16,
  parameter int EN_ADDI = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rt_dst,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             ex_regdst,
  output logic             ex_alusrc,
  output logic             ex_memread,
  output logic [1:0]       ex_aluop,
  output logic [RA_W-1:0]  ex_rt,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_branch,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic             illegal_op,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ex_ctrl_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_ctrl_t         ex_q, ex_d, dec;
  mem_ctrl_t        mem_q, mem_d;
  wb_ctrl_t         wb_q, wb_d;
  logic [RA_W-1:0]  ex_rt_q, ex_rt_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             dec_legal, hazard, br, stall, bubble;

  always_comb begin
    dec       = '0;
    dec_legal = 1'b1;
    case (op)
      6'd0:    dec = ex_ctrl_t'(9'b1_0_0_1_0_0_0_10);
      6'd35:   dec = ex_ctrl_t'(9'b0_1_1_1_1_0_0_00);
      6'd43:   dec = ex_ctrl_t'(9'b0_1_0_0_0_1_0_00);
      6'd4:    dec = ex_ctrl_t'(9'b0_0_0_0_0_0_1_01);
      6'd8: begin
        if (EN_ADDI != 0) dec = ex_ctrl_t'(9'b0_1_0_1_0_0_0_00);
        else              dec_legal = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Reset masks branch_taken so the fetch side sees plain "advance" while rst is high.
  always_comb begin
    br     = branch_taken & ~rst;
    hazard = ex_q.memread & (ex_rt_q != '0) & ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));
    stall  = hazard & ~br;
    bubble = hazard | br;

    pc_write   = ~stall;
    ifid_write = ~stall;
    ifid_flush = br;
  end

  always_comb begin
    ex_d    = bubble ? '0 : dec;
    ex_rt_d = bubble ? '0 : id_rt_dst;

    mem_d = '0;
    if (!br) begin
      mem_d.memtoreg = ex_q.memtoreg;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.memread  = ex_q.memread;
      mem_d.memwrite = ex_q.memwrite;
      mem_d.branch   = ex_q.branch;
    end

    wb_d.memtoreg = mem_q.memtoreg;
    wb_d.regwrite = mem_q.regwrite;

    // A stalled instruction is re-presented and a flushed one never executes.
    illegal_d = illegal_q | (~dec_legal & ~bubble);

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    flush_cnt_d = flush_cnt_q;
    if (br && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      ex_rt_q     <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_rt_q     <= ex_rt_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_regdst    = ex_q.regdst;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_memread   = ex_q.memread;
  assign ex_aluop     = ex_q.aluop;
  assign ex_rt        = ex_rt_q;
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign mem_branch   = mem_q.branch;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_memtoreg  = wb_q.memtoreg;
  assign illegal_op   = illegal_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: two instances (addi enabled / disabled, 4-bit counters)
// driven by shared random and directed stimulus, compared against an instruction-level model.
module tb_pipe_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rt_dst = '0;
  logic       branch_taken = 1'b0;

  logic       pc_write0, ifid_write0, ifid_flush0, ex_regdst0, ex_alusrc0, ex_memread0;
  logic [1:0] ex_aluop0;
  logic [4:0] ex_rt0;
  logic       mem_memread0, mem_memwrite0, mem_branch0, wb_regwrite0, wb_memtoreg0, illegal_op0;
  logic [3:0] stall_cnt0, flush_cnt0;

  logic       pc_write1, ifid_write1, ifid_flush1, ex_regdst1, ex_alusrc1, ex_memread1;
  logic [1:0] ex_aluop1;
  logic [4:0] ex_rt1;
  logic       mem_memread1, mem_memwrite1, mem_branch1, wb_regwrite1, wb_memtoreg1, illegal_op1;
  logic [3:0] stall_cnt1, flush_cnt1;

  always #5 clk = ~clk;

  pipe_control #(.RA_W(5), .CNT_W(4), .EN_ADDI(1)) u_dut0 (
    .clk(clk), .rst(rst), .op(op), .id_rs(id_rs), .id_rt(id_rt), .id_rt_dst(id_rt_dst),
    .branch_taken(branch_taken), .pc_write(pc_write0), .ifid_write(ifid_write0),
    .ifid_flush(ifid_flush0), .ex_regdst(ex_regdst0), .ex_alusrc(ex_alusrc0),
    .ex_memread(ex_memread0), .ex_aluop(ex_aluop0), .ex_rt(ex_rt0),
    .mem_memread(mem_memread0), .mem_memwrite(mem_memwrite0), .mem_branch(mem_branch0),
    .wb_regwrite(wb_regwrite0), .wb_memtoreg(wb_memtoreg0), .illegal_op(illegal_op0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

  pipe_control #(.RA_W(5), .CNT_W(4), .EN_ADDI(0)) u_dut1 (
    .clk(clk), .rst(rst), .op(op), .id_rs(id_rs), .id_rt(id_rt), .id_rt_dst(id_rt_dst),
    .branch_taken(branch_taken), .pc_write(pc_write1), .ifid_write(ifid_write1),
    .ifid_flush(ifid_flush1), .ex_regdst(ex_regdst1), .ex_alusrc(ex_alusrc1),
    .ex_memread(ex_memread1), .ex_aluop(ex_aluop1), .ex_rt(ex_rt1),
    .mem_memread(mem_memread1), .mem_memwrite(mem_memwrite1), .mem_branch(mem_branch1),
    .wb_regwrite(wb_regwrite1), .wb_memtoreg(wb_memtoreg1), .illegal_op(illegal_op1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

  logic [26:0] obs0, obs1;
  assign obs0 = {pc_write0, ifid_write0, ifid_flush0, ex_regdst0, ex_alusrc0, ex_memread0,
                 ex_aluop0, ex_rt0, mem_memread0, mem_memwrite0, mem_branch0,
                 wb_regwrite0, wb_memtoreg0, illegal_op0, stall_cnt0, flush_cnt0};
  assign obs1 = {pc_write1, ifid_write1, ifid_flush1, ex_regdst1, ex_alusrc1, ex_memread1,
                 ex_aluop1, ex_rt1, mem_memread1, mem_memwrite1, mem_branch1,
                 wb_regwrite1, wb_memtoreg1, illegal_op1, stall_cnt1, flush_cnt1};

  localparam logic [26:0] RST_V = {3'b110, 24'd0};

  // Model: each instruction carries its control word {regdst,alusrc,memtoreg,regwrite,
  // memread,memwrite,branch,aluop[1:0]} through the stages it reaches.
  typedef struct {
    logic [8:0] ex_c;
    logic [4:0] ex_rt;
    logic [8:0] mem_c;
    logic [8:0] wb_c;
    bit         ill;
    int         sc;
    int         fc;
  } mstate_t;

  typedef struct packed {
    logic [26:0] v0;
    logic [26:0] v1;
  } exp_t;

  mstate_t m[2];
  exp_t    sb_q[$];
  int      errors = 0;
  int      checks = 0;

  function automatic logic [9:0] decode(input logic [5:0] o, input bit en_addi);
    case (o)
      6'd0:    return 10'b1_100100010;
      6'd35:   return 10'b1_011110000;
      6'd43:   return 10'b1_010001000;
      6'd4:    return 10'b1_000000101;
      6'd8:    return en_addi ? 10'b1_010100000 : 10'b0_000000000;
      default: return 10'b0_000000000;
    endcase
  endfunction

  function automatic logic [26:0] expect_vec(input mstate_t s, input bit pc, input bit fl);
    return {pc, pc, fl, s.ex_c[8], s.ex_c[7], s.ex_c[4], s.ex_c[1:0], s.ex_rt,
            s.mem_c[4], s.mem_c[3], s.mem_c[2], s.wb_c[5], s.wb_c[6], s.ill,
            4'(s.sc), 4'(s.fc)};
  endfunction

  task automatic chk(input string name, input logic [26:0] got, input logic [26:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].ex_c = '0; m[k].ex_rt = '0; m[k].mem_c = '0; m[k].wb_c = '0;
      m[k].ill = 1'b0; m[k].sc = 0; m[k].fc = 0;
    end
  endtask

  task automatic model_cycle(input bit do_push);
    logic [26:0] v[2];
    logic [9:0]  d;
    bit          hz, stall;
    for (int k = 0; k < 2; k++) begin
      hz    = m[k].ex_c[4] && (m[k].ex_rt != 0) && (m[k].ex_rt == id_rs || m[k].ex_rt == id_rt);
      stall = hz && !branch_taken;
      v[k]  = expect_vec(m[k], !stall, branch_taken);
      d     = decode(op, k == 0);
      m[k].wb_c  = m[k].mem_c;
      m[k].mem_c = branch_taken ? 9'd0 : m[k].ex_c;
      m[k].ex_c  = (branch_taken || hz) ? 9'd0 : d[8:0];
      m[k].ex_rt = (branch_taken || hz) ? 5'd0 : id_rt_dst;
      if (!d[9] && !branch_taken && !hz) m[k].ill = 1'b1;
      if (stall && m[k].sc < 15) m[k].sc++;
      if (branch_taken && m[k].fc < 15) m[k].fc++;
    end
    if (do_push) sb_q.push_back('{v0: v[0], v1: v[1]});
  endtask

  task automatic step(input logic [5:0] o, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rtd, input bit b);
    @(posedge clk);
    #2;
    op = o; id_rs = rs; id_rt = rt; id_rt_dst = rtd; branch_taken = b;
    model_cycle(1'b1);
  endtask

  // Holds rst over one full edge, then releases it mid-cycle with a branch pending.
  task automatic step_reset();
    @(posedge clk);
    #2;
    op = 6'($urandom_range(0, 63)); id_rs = 5'd0; id_rt = 5'd0;
    id_rt_dst = 5'($urandom_range(0, 31)); branch_taken = 1'b1;
    sb_q.push_back('{v0: RST_V, v1: RST_V});
    #4;
    rst = 1'b0;
    model_reset();
    model_cycle(1'b0);
  endtask

  task automatic reset_mid_cycle();
    #5;
    rst = 1'b1;
    #1;
    chk("async_reset_dut0", obs0, RST_V);
    chk("async_reset_dut1", obs1, RST_V);
    model_reset();
    step_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("cycle_dut0", obs0, e.v0);
        chk("cycle_dut1", obs1, e.v1);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int sel;
    logic [5:0] o;
    model_reset();
    step_reset();

    // r-type, lw, sw, beq back to back without hazards
    step(6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
    step(6'd35, 5'd0, 5'd0, 5'd4, 1'b0);
    step(6'd43, 5'd0, 5'd0, 5'd0, 1'b0);
    step(6'd4, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (4) step(6'd0, 5'd0, 5'd0, 5'd0, 1'b0);

    // load-use stall, then the same pair with rt=0 (no stall)
    step(6'd35, 5'd0, 5'd0, 5'd5, 1'b0);
    step(6'd0, 5'd5, 5'd0, 5'd1, 1'b0);
    step(6'd0, 5'd5, 5'd0, 5'd1, 1'b0);
    step(6'd35, 5'd0, 5'd0, 5'd0, 1'b0);
    step(6'd0, 5'd0, 5'd0, 5'd1, 1'b0);

    // branch coincident with load-use, then illegal op during stall and during branch
    step(6'd35, 5'd0, 5'd0, 5'd6, 1'b0);
    step(6'd0, 5'd0, 5'd6, 5'd1, 1'b1);
    step(6'd35, 5'd0, 5'd0, 5'd7, 1'b0);
    step(6'd63, 5'd7, 5'd0, 5'd1, 1'b0);
    step(6'd63, 5'd0, 5'd0, 5'd1, 1'b1);
    step(6'd8, 5'd0, 5'd0, 5'd2, 1'b0);
    repeat (3) step(6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(6'd63, 5'd0, 5'd0, 5'd0, 1'b0);
    step(6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    reset_mid_cycle();

    repeat (400) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    o = 6'd0;
        2, 3:    o = 6'd35;
        4:       o = 6'd43;
        5:       o = 6'd4;
        6, 7:    o = 6'd8;
        default: o = 6'($urandom_range(0, 63));
      endcase
      step(o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0);
    end

    // saturate the 4-bit stall counter, then reset in the middle of a stall
    repeat (19) begin
      step(6'd35, 5'd0, 5'd0, 5'd5, 1'b0);
      step(6'd0, 5'd5, 5'd0, 5'd1, 1'b0);
    end
    repeat (20) step(6'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    step(6'd35, 5'd0, 5'd0, 5'd5, 1'b0);
    step(6'd0, 5'd5, 5'd0, 5'd1, 1'b0);
    reset_mid_cycle();
    repeat (4) step(6'd8, 5'd0, 5'd0, 5'd0, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
